module_control_calc: RTL and testbench
======================================

MODULE_CONTROL_CALC -- requirements
Module: module_control_calc

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, sets the maximum number of cycles spent in WAIT_MUL before an error is flagged.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 key_valid  input  1  one-cycle strobe from the keypad decoder; key_code is valid when high.
REQ-005 key_code  input  4  0x0-0x9 = digit, 0xA = enter, 0xB = clear; all other codes are ignored.
REQ-006 mul_done  input  1  one-cycle completion strobe from the multiplier.
REQ-007 mul_result  input  16  multiplier product; valid when mul_done is high.
REQ-008 op_a  output  8  operand A, driven to the multiplier.
REQ-009 op_b  output  8  operand B, driven to the multiplier.
REQ-010 mul_start  output  1  one-cycle multiplier launch strobe.
REQ-011 result  output  16  registered product.
REQ-012 result_valid  output  1  high while result is shown.
REQ-013 state_o  output  3  current FSM state encoding, for display and debug.
REQ-014 digit_cnt  output  2  number of digits accepted for the operand being entered (0-3).
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 FSM states: ENTER_A, ENTER_B, START_MUL, WAIT_MUL, SHOW, FAULT.
REQ-017 ENTER_A and ENTER_B behaviour:
- A digit d updates the active operand to acc*10+d one cycle after key_valid and increments digit_cnt.
- Digits are accepted only while digit_cnt<3 and acc*10+d<=255.
- A rejected digit leaves acc unchanged and sets err.
REQ-018 Enter handling:
- Enter with digit_cnt=0 is ignored.
- Enter in ENTER_A with at least 1 digit moves to ENTER_B and clears digit_cnt.
- Enter in ENTER_B with at least 1 digit moves to START_MUL.
REQ-019 mul_start is high for exactly the single cycle spent in START_MUL; the next state is WAIT_MUL unconditionally.
REQ-020 op_a and op_b hold constant from START_MUL until the FSM leaves SHOW.
REQ-021 WAIT_MUL behaviour:
- On mul_done, result takes mul_result and the FSM moves to SHOW.
- result_valid goes high on the cycle after mul_done.
REQ-022 Timeout:
- The WAIT_MUL cycle counter starts at 0 on entry.
- When the count reaches TIMEOUT_CYCLES without mul_done, the FSM moves to FAULT and err is set.
REQ-023 mul_done outside WAIT_MUL is ignored.
REQ-024 Digit and enter keys are ignored in START_MUL, WAIT_MUL and FAULT.
REQ-025 In SHOW, enter is ignored; a digit d performs all of the following on the next cycle:
- clears result_valid, op_b and err;
- loads op_a=d with digit_cnt=1;
- moves to ENTER_A.
REQ-026 Clear (0xB) in any state takes effect on the next cycle:
- moves to ENTER_A;
- zeroes op_a, op_b, digit_cnt, result, result_valid and err.
REQ-027 Clear coincident with mul_done: clear wins and the product is discarded.
REQ-028 Accepted digits and accepted enter in ENTER_A or ENTER_B clear err; rejected digits set it.

Reset
REQ-029 While rst is low, asynchronously:
- state=ENTER_A;
- op_a=0, op_b=0, digit_cnt=0;
- mul_start=0, result=0, result_valid=0, err=0;
- timeout counter=0.
REQ-030 Reset asserted mid-operation, including WAIT_MUL, aborts the operation; a later mul_done is ignored.

Structure
REQ-031 Package calc_pkg holds the state enum, the key-code constants (KEY_ENTER=0xA, KEY_CLEAR=0xB) and OPERAND_MAX=255.
REQ-032 Sub-module module_acum_dec implements the operand accumulator:
- performs the acc*10+d computation and the overflow/count check;
- provides a load, clear and accept interface;
- one instance is shared between the A and B phases.

Verification
REQ-033 Keys 1,2,A,3,4,A, then mul_done with mul_result=408 -> op_a=12, op_b=34, mul_start pulses once, result=408, result_valid=1, state SHOW.
REQ-034 Keys 2,5,6 in ENTER_A -> op_a=25, digit_cnt=2, err=1; then key 5 -> op_a=255, err=0.
REQ-035 Keys A with no digits, then 7,A -> first A ignored, state ENTER_B, op_a=7.
REQ-036 Keys 9,A,4,B -> state ENTER_A, op_a=0, op_b=0, digit_cnt=0.
REQ-037 Keys 3,A,5,A with mul_done withheld -> FAULT and err=1 after TIMEOUT_CYCLES cycles; then B -> ENTER_A, err=0.
REQ-038 rst low during WAIT_MUL, then mul_done -> all outputs at reset values, result_valid stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad-driven multiply calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A   = 3'd0,
    ENTER_B   = 3'd1,
    START_MUL = 3'd2,
    WAIT_MUL  = 3'd3,
    SHOW      = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam int         OPERAND_MAX   = 255;
  localparam logic [1:0] DIGIT_CNT_MAX = 2'd3;

endpackage

// File: rtl/module_acum_dec.sv
// Decimal operand accumulator: acc*10+d with range and digit-count check.
module module_acum_dec
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       accept,
  input  logic [3:0] digit,
  output logic [7:0] acc,
  output logic [7:0] acc_nxt,
  output logic [1:0] cnt,
  output logic       ok
);

  logic [11:0] prod;

  // acc*10 as acc*8 + acc*2; 12 bits covers 255*10+9 without wrap
  assign prod    = {1'b0, acc, 3'b000} + {3'b000, acc, 1'b0} + {8'd0, digit};
  assign ok      = (cnt != DIGIT_CNT_MAX) && (prod <= 12'(OPERAND_MAX));
  assign acc_nxt = prod[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 8'd0;
      cnt <= 2'd0;
    end else if (clear) begin
      acc <= 8'd0;
      cnt <= 2'd0;
    end else if (load) begin
      acc <= {4'd0, digit};
      cnt <= 2'd1;
    end else if (accept && ok) begin
      acc <= acc_nxt;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/module_control_calc.sv
// Calculator controller: collects two decimal operands, launches the
// multiplier, shows the product and flags overflow/timeout errors.
module module_control_calc
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        mul_start,
  output logic [15:0] result,
  output logic        result_valid,
  output logic [2:0]  state_o,
  output logic [1:0]  digit_cnt,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            key_digit, key_enter, key_clear;
  logic            in_entry, enter_ok;
  logic            acc_clear, acc_load, acc_accept, acc_ok;
  logic [7:0]      acc, acc_nxt;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_enter = key_valid && (key_code == KEY_ENTER);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign in_entry  = (state == ENTER_A) || (state == ENTER_B);
  assign enter_ok  = key_enter && (digit_cnt != 2'd0);
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // The accumulator is restarted between the A and B phases
  assign acc_clear  = key_clear || ((state == ENTER_A) && enter_ok);
  assign acc_load   = (state == SHOW) && key_digit;
  assign acc_accept = in_entry && key_digit;

  module_acum_dec u_acum (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .load    (acc_load),
    .accept  (acc_accept),
    .digit   (key_code),
    .acc     (acc),
    .acc_nxt (acc_nxt),
    .cnt     (digit_cnt),
    .ok      (acc_ok)
  );

  assign mul_start = (state == START_MUL);
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ENTER_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_clear) begin
      state_nxt = ENTER_A;
    end else begin
      case (state)
        ENTER_A:   if (enter_ok) state_nxt = ENTER_B;
        ENTER_B:   if (enter_ok) state_nxt = START_MUL;
        START_MUL: state_nxt = WAIT_MUL;
        WAIT_MUL: begin
          if (mul_done)     state_nxt = SHOW;
          else if (tmo_hit) state_nxt = FAULT;
        end
        SHOW:      if (key_digit) state_nxt = ENTER_A;
        FAULT:     state_nxt = FAULT;
        default:   state_nxt = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT_MUL) && !key_clear) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a         <= 8'd0;
      op_b         <= 8'd0;
      result       <= 16'd0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else if (key_clear) begin
      op_a         <= 8'd0;
      op_b         <= 8'd0;
      result       <= 16'd0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (key_digit) begin
            if (acc_ok) begin
              if (state == ENTER_A) op_a <= acc_nxt;
              else                  op_b <= acc_nxt;
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else if (enter_ok) begin
            err <= 1'b0;
          end
        end
        WAIT_MUL: begin
          if (mul_done) begin
            result       <= mul_result;
            result_valid <= 1'b1;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end
        end
        SHOW: begin
          if (key_digit) begin
            op_a         <= {4'd0, key_code};
            op_b         <= 8'd0;
            result_valid <= 1'b0;
            err          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_module_control_calc.sv
// Directed bench for module_control_calc: vector table plus timeout and
// mid-operation reset sequences.
module tb_module_control_calc;
  import calc_pkg::*;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [7:0]  op_a, op_b;
  logic        mul_start;
  logic [15:0] result;
  logic        result_valid;
  logic [2:0]  state_o;
  logic [1:0]  digit_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  module_control_calc #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .mul_done     (mul_done),
    .mul_result   (mul_result),
    .op_a         (op_a),
    .op_b         (op_b),
    .mul_start    (mul_start),
    .result       (result),
    .result_valid (result_valid),
    .state_o      (state_o),
    .digit_cnt    (digit_cnt),
    .err          (err)
  );

  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic        md;
    logic [15:0] mr;
    logic [2:0]  st;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  dc;
    logic        e;
    logic        rv;
    logic [15:0] res;
    logic        ms;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic kv, input logic [3:0] code, input logic md,
                   input logic [15:0] mr, input logic [2:0] st, input logic [7:0] a,
                   input logic [7:0] b, input logic [1:0] dc, input logic e,
                   input logic rv, input logic [15:0] res, input logic ms);
    vec_t t;
    t.kv = kv; t.code = code; t.md = md; t.mr = mr; t.st = st; t.a = a;
    t.b = b; t.dc = dc; t.e = e; t.rv = rv; t.res = res; t.ms = ms;
    vecs.push_back(t);
  endtask

  function automatic logic [39:0] pack(input logic [2:0] st, input logic [7:0] a,
                                       input logic [7:0] b, input logic [1:0] dc,
                                       input logic e, input logic rv,
                                       input logic [15:0] res, input logic ms);
    return {st, a, b, dc, e, rv, res, ms};
  endfunction

  task automatic check_all(input string name, input logic [2:0] st, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] dc, input logic e,
                           input logic rv, input logic [15:0] res, input logic ms);
    logic [39:0] got, exp;
    got = pack(state_o, op_a, op_b, digit_cnt, err, result_valid, result, mul_start);
    exp = pack(st, a, b, dc, e, rv, res, ms);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d a=%0d b=%0d dc=%0d err=%0b rv=%0b res=%0d ms=%0b, want st=%0d a=%0d b=%0d dc=%0d err=%0b rv=%0b res=%0d ms=%0b",
               name, state_o, op_a, op_b, digit_cnt, err, result_valid, result, mul_start,
               st, a, b, dc, e, rv, res, ms);
    end
  endtask

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Called at a negedge: apply inputs for one cycle, return at next negedge
  task automatic step(input logic kv, input logic [3:0] code, input logic md,
                      input logic [15:0] mr);
    key_valid  = kv;
    key_code   = code;
    mul_done   = md;
    mul_result = mr;
    @(posedge clk);
    @(negedge clk);
    key_valid  = 1'b0;
    key_code   = 4'hF;
    mul_done   = 1'b0;
    mul_result = 16'd0;
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b1, code, 1'b0, 16'd0);
  endtask

  localparam logic [2:0] SA = 3'(ENTER_A);
  localparam logic [2:0] SB = 3'(ENTER_B);
  localparam logic [2:0] SS = 3'(START_MUL);
  localparam logic [2:0] SW = 3'(WAIT_MUL);
  localparam logic [2:0] SH = 3'(SHOW);
  localparam logic [2:0] SF = 3'(FAULT);

  initial begin
    int n;
    rst        = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'hF;
    mul_done   = 1'b0;
    mul_result = 16'd0;

    // kv code md mr | st a b dc err rv res ms
    v(1, 4'h1, 0, 0,     SA, 1,   0,  1, 0, 0, 0,   0);
    v(1, 4'h2, 0, 0,     SA, 12,  0,  2, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SB, 12,  0,  0, 0, 0, 0,   0);
    v(1, 4'h3, 0, 0,     SB, 12,  3,  1, 0, 0, 0,   0);
    v(1, 4'h4, 0, 0,     SB, 12,  34, 2, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SS, 12,  34, 2, 0, 0, 0,   1);
    v(0, 4'hF, 0, 0,     SW, 12,  34, 2, 0, 0, 0,   0);
    v(0, 4'hF, 0, 0,     SW, 12,  34, 2, 0, 0, 0,   0);
    v(0, 4'hF, 1, 408,   SH, 12,  34, 2, 0, 1, 408, 0);
    v(0, 4'hF, 1, 999,   SH, 12,  34, 2, 0, 1, 408, 0);
    v(1, 4'hA, 0, 0,     SH, 12,  34, 2, 0, 1, 408, 0);
    v(1, 4'h7, 0, 0,     SA, 7,   0,  1, 0, 0, 408, 0);
    v(1, 4'hB, 0, 0,     SA, 0,   0,  0, 0, 0, 0,   0);
    v(1, 4'h2, 0, 0,     SA, 2,   0,  1, 0, 0, 0,   0);
    v(1, 4'h5, 0, 0,     SA, 25,  0,  2, 0, 0, 0,   0);
    v(1, 4'h6, 0, 0,     SA, 25,  0,  2, 1, 0, 0,   0);
    v(1, 4'h5, 0, 0,     SA, 255, 0,  3, 0, 0, 0,   0);
    v(1, 4'h1, 0, 0,     SA, 255, 0,  3, 1, 0, 0,   0);
    v(1, 4'hC, 0, 0,     SA, 255, 0,  3, 1, 0, 0,   0);
    v(1, 4'hB, 0, 0,     SA, 0,   0,  0, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SA, 0,   0,  0, 0, 0, 0,   0);
    v(1, 4'h7, 0, 0,     SA, 7,   0,  1, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SB, 7,   0,  0, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SB, 7,   0,  0, 0, 0, 0,   0);
    v(1, 4'hB, 0, 0,     SA, 0,   0,  0, 0, 0, 0,   0);
    v(1, 4'h9, 0, 0,     SA, 9,   0,  1, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SB, 9,   0,  0, 0, 0, 0,   0);
    v(1, 4'h4, 0, 0,     SB, 9,   4,  1, 0, 0, 0,   0);
    v(1, 4'hB, 0, 0,     SA, 0,   0,  0, 0, 0, 0,   0);
    v(1, 4'h3, 0, 0,     SA, 3,   0,  1, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SB, 3,   0,  0, 0, 0, 0,   0);
    v(1, 4'h5, 0, 0,     SB, 3,   5,  1, 0, 0, 0,   0);
    v(1, 4'hA, 0, 0,     SS, 3,   5,  1, 0, 0, 0,   1);
    v(1, 4'h8, 0, 0,     SW, 3,   5,  1, 0, 0, 0,   0);
    v(1, 4'h8, 0, 0,     SW, 3,   5,  1, 0, 0, 0,   0);
    v(1, 4'hB, 1, 16'h1234, SA, 0, 0, 0, 0, 0, 0,   0);
    v(0, 4'hF, 1, 5,     SA, 0,   0,  0, 0, 0, 0,   0);

    repeat (2) @(negedge clk);
    check_all("reset", SA, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].md, vecs[i].mr);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].dc,
                vecs[i].e, vecs[i].rv, vecs[i].res, vecs[i].ms);
    end

    // Timeout with mul_done withheld
    key(4'h3); key(4'hA); key(4'h5); key(4'hA);
    check1("tmo_start", 16'(state_o), 16'(SS));
    n = 0;
    while (state_o != SF && n < 2 * TMO + 10) begin
      step(1'b0, 4'hF, 1'b0, 16'd0);
      n++;
      if (n == TMO - 1) check1("tmo_still_wait", 16'(state_o), 16'(SW));
    end
    checks++;
    if (n < TMO || n > TMO + 2) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d want %0d..%0d", n, TMO, TMO + 2);
    end
    check_all("tmo_fault", SF, 3, 5, 1, 1, 0, 0, 0);
    key(4'h4);
    check_all("fault_key_ignored", SF, 3, 5, 1, 1, 0, 0, 0);
    key(4'hB);
    check_all("fault_clear", SA, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset during WAIT_MUL, then a stale mul_done
    key(4'h6); key(4'hA); key(4'h2); key(4'hA);
    step(1'b0, 4'hF, 1'b0, 16'd0);
    check1("rst_pre_wait", 16'(state_o), 16'(SW));
    #2 rst = 1'b0;
    #1 check_all("rst_async", SA, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 4'hF, 1'b1, 16'd12);
    check_all("rst_stale_done", SA, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 4'hF, 1'b0, 16'd0);
    check1("rst_rv_low", 16'(result_valid), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
